// File: rtl/mux_scan_pkg.sv
// -----------------------------------------------------------------------------
// mux_scan_pkg
// Shared definitions for the mux_scan_sel channel selector: the 2-bit
// operating-mode type and its encodings.
// -----------------------------------------------------------------------------
package mux_scan_pkg;

    // Operating mode. 2'b11 is reserved and behaves like freeze.
    typedef enum logic [1:0] {
        MODE_MANUAL = 2'b00,
        MODE_SCAN   = 2'b01,
        MODE_FREEZE = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_t;

endpackage : mux_scan_pkg

// File: rtl/mux_scan_div.sv
// -----------------------------------------------------------------------------
// mux_scan_div
// Scan-step prescaler. Counts 0..SCAN_DIV-1 while enabled and raises tc
// combinationally during the last count, so the owner can advance on the
// same edge that wraps the counter.
//
// Ports
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset (count -> 0)
//   clr    : synchronous clear to 0; wins over en and suppresses tc
//   en     : count enable; when low the count holds
//   tc     : terminal count (en && !clr && count == SCAN_DIV-1)
// -----------------------------------------------------------------------------
module mux_scan_div #(
    parameter int SCAN_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    // A one-cycle divider still needs a 1-bit counter to stay legal.
    localparam int            CW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt;

    assign tc = en && !clr && (cnt == LAST);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // values from before the edge, regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + 1'b1;
        end
    end

endmodule : mux_scan_div

// File: rtl/mux_scan_sel.sv
// -----------------------------------------------------------------------------
// mux_scan_sel
// Registered N-to-1 channel selector with manual, scan and freeze modes.
// dout and ch are loaded together from the same next index, so they always
// describe the same channel one cycle after din.
//
// Ports
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   mode     : 00 manual, 01 scan, 10 freeze, 11 reserved (freeze)
//   sel      : channel index used in manual mode
//   en_mask  : per-channel enable used in scan mode
//   din      : flattened channels, channel k at [k*WIDTH +: WIDTH]
//   dout     : registered data of the selected channel
//   ch       : registered index of the channel on dout
//   valid    : dout holds legal, enabled channel data
//   step     : one-cycle pulse when the scan index advances
// -----------------------------------------------------------------------------
module mux_scan_sel
    import mux_scan_pkg::*;
#(
    parameter int WIDTH    = 9,
    parameter int CHANNELS = 8,
    parameter int SCAN_DIV = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [1:0]                    mode,
    input  logic [$clog2(CHANNELS)-1:0]   sel,
    input  logic [CHANNELS-1:0]           en_mask,
    input  logic [CHANNELS*WIDTH-1:0]     din,
    output logic [WIDTH-1:0]              dout,
    output logic [$clog2(CHANNELS)-1:0]   ch,
    output logic                          valid,
    output logic                          step
);

    localparam int SELW = $clog2(CHANNELS);

    mode_t            md;
    logic             is_scan;
    logic             was_scan;
    logic             tc;

    logic [SELW-1:0]  next_ch;
    logic [SELW-1:0]  lo_idx;
    logic [SELW-1:0]  hi_idx;
    logic             hi_found;

    logic [SELW-1:0]  ch_nx;
    logic             upd;
    logic             step_nx;
    logic             hit;
    logic [WIDTH-1:0] ch_data;
    logic             ch_en;
    logic             valid_nx;

    assign md      = mode_t'(mode);
    assign is_scan = (md == MODE_SCAN);

    // The first scan-mode edge restarts the dwell from zero.
    mux_scan_div #(
        .SCAN_DIV (SCAN_DIV)
    ) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (is_scan && !was_scan),
        .en    (is_scan),
        .tc    (tc)
    );

    // Next enabled channel strictly above ch, else the lowest enabled one.
    // Scanning downwards lets the last hit be the lowest index. An index
    // outside 0..CHANNELS-1 has nothing above it, so it wraps to the lowest.
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        lo_idx   = '0;
        hi_idx   = '0;
        hi_found = 1'b0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (en_mask[k]) begin
                lo_idx = SELW'(k);
                if (k > int'(ch)) begin
                    hi_idx   = SELW'(k);
                    hi_found = 1'b1;
                end
            end
        end
        next_ch = hi_found ? hi_idx : lo_idx;
    end

    // Next index per mode; freeze and reserved leave everything untouched.
    always_comb begin
        ch_nx   = ch;
        upd     = 1'b0;
        step_nx = 1'b0;
        case (md)
            MODE_MANUAL: begin
                ch_nx = sel;
                upd   = 1'b1;
            end
            MODE_SCAN: begin
                upd = 1'b1;
                if (tc && (en_mask != '0)) begin
                    ch_nx   = next_ch;
                    step_nx = 1'b1;
                end
            end
            default: begin
                upd = 1'b0;
            end
        endcase
    end

    // Data and enable of ch_nx; an out-of-range index reads as 0 / disabled.
    always_comb begin
        hit     = 1'b0;
        ch_data = '0;
        ch_en   = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (ch_nx == SELW'(k)) begin
                hit     = 1'b1;
                ch_data = din[k*WIDTH +: WIDTH];
                ch_en   = en_mask[k];
            end
        end
        valid_nx = (md == MODE_MANUAL) ? hit : ch_en;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout     <= '0;
            ch       <= '0;
            valid    <= 1'b0;
            step     <= 1'b0;
            was_scan <= 1'b0;
        end else begin
            was_scan <= is_scan;
            step     <= step_nx;
            if (upd) begin
                ch    <= ch_nx;
                dout  <= ch_data;
                valid <= valid_nx;
            end
        end
    end

endmodule : mux_scan_sel

// File: tb/tb_mux_scan_sel.sv
// -----------------------------------------------------------------------------
// tb_mux_scan_sel
// Directed bench for mux_scan_sel. Instance a: 8 channels, 4-cycle dwell.
// Instance b: 5 channels (out-of-range sel possible), 1-cycle dwell.
// Drivers push the hand-computed response for each edge; a monitor pops it
// just after the edge and compares.
// -----------------------------------------------------------------------------
module tb_mux_scan_sel;

    typedef struct packed {
        logic        which;   // 0: instance a, 1: instance b
        logic [15:0] id;
        logic [8:0]  dout;
        logic [2:0]  ch;
        logic        valid;
        logic        step;
    } exp_t;

    localparam logic [1:0] MAN = 2'b00;
    localparam logic [1:0] SCN = 2'b01;
    localparam logic [1:0] FRZ = 2'b10;
    localparam logic [1:0] RSV = 2'b11;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;

    logic [1:0]  mode_a = FRZ;
    logic [2:0]  sel_a  = '0;
    logic [7:0]  mask_a = '0;
    logic [71:0] din_a;
    logic [8:0]  dout_a;
    logic [2:0]  ch_a;
    logic        valid_a;
    logic        step_a;

    logic [1:0]  mode_b = FRZ;
    logic [2:0]  sel_b  = '0;
    logic [4:0]  mask_b = '0;
    logic [44:0] din_b;
    logic [8:0]  dout_b;
    logic [2:0]  ch_b;
    logic        valid_b;
    logic        step_b;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          id_n  = 0;

    always #5 clk = ~clk;

    mux_scan_sel #(.WIDTH(9), .CHANNELS(8), .SCAN_DIV(4)) u_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .mode    (mode_a),
        .sel     (sel_a),
        .en_mask (mask_a),
        .din     (din_a),
        .dout    (dout_a),
        .ch      (ch_a),
        .valid   (valid_a),
        .step    (step_a)
    );

    mux_scan_sel #(.WIDTH(9), .CHANNELS(5), .SCAN_DIV(1)) u_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .mode    (mode_b),
        .sel     (sel_b),
        .en_mask (mask_b),
        .din     (din_b),
        .dout    (dout_b),
        .ch      (ch_b),
        .valid   (valid_b),
        .step    (step_b)
    );

    // Default data of instance a, channel k.
    function automatic logic [8:0] da(input int k);
        return 9'h100 + 9'(k * 17);
    endfunction

    task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got dout=%h ch=%0d valid=%b step=%b, want dout=%h ch=%0d valid=%b step=%b",
                     name, act[13:5], act[4:2], act[1], act[0], exp[13:5], exp[4:2], exp[1], exp[0]);
        end
    endtask

    // Called at a falling edge: apply inputs, record the response expected
    // after the coming rising edge, then move on to the next falling edge.
    task automatic drive_a(input logic [1:0] m, input logic [2:0] s, input logic [7:0] mk,
                           input logic [8:0] ed, input logic [2:0] ec, input logic ev, input logic es);
        mode_a = m;
        sel_a  = s;
        mask_a = mk;
        sb.push_back('{which: 1'b0, id: 16'(id_n), dout: ed, ch: ec, valid: ev, step: es});
        id_n++;
        @(negedge clk);
    endtask

    task automatic drive_b(input logic [1:0] m, input logic [2:0] s, input logic [4:0] mk,
                           input logic [8:0] ed, input logic [2:0] ec, input logic ev, input logic es);
        mode_b = m;
        sel_b  = s;
        mask_b = mk;
        sb.push_back('{which: 1'b1, id: 16'(id_n), dout: ed, ch: ec, valid: ev, step: es});
        id_n++;
        @(negedge clk);
    endtask

    // Monitor: one expectation per rising edge, sampled 1 time unit later.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                if (!e.which)
                    check($sformatf("a#%0d", e.id), {dout_a, ch_a, valid_a, step_a},
                          {e.dout, e.ch, e.valid, e.step});
                else
                    check($sformatf("b#%0d", e.id), {dout_b, ch_b, valid_b, step_b},
                          {e.dout, e.ch, e.valid, e.step});
            end
        end
    end

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int seq[5];
        seq = '{0, 2, 5, 7, 0};
        for (int k = 0; k < 8; k++) din_a[k*9 +: 9] = da(k);
        for (int k = 0; k < 5; k++) din_b[k*9 +: 9] = 9'h080 + 9'(k);

        // Reset state
        #1;
        check("rst_a", {dout_a, ch_a, valid_a, step_a}, 14'h0);
        check("rst_b", {dout_b, ch_b, valid_b, step_b}, 14'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- instance b: out-of-range manual, wrap from sel=6, 1-cycle dwell
        drive_b(MAN, 3'd6, 5'h00, 9'h000, 3'd6, 1'b0, 1'b0);
        drive_b(MAN, 3'd4, 5'h00, 9'h084, 3'd4, 1'b1, 1'b0);
        drive_b(MAN, 3'd6, 5'h00, 9'h000, 3'd6, 1'b0, 1'b0);
        drive_b(SCN, 3'd0, 5'h1F, 9'h000, 3'd6, 1'b0, 1'b0);  // prescaler cleared
        drive_b(SCN, 3'd0, 5'h1F, 9'h080, 3'd0, 1'b1, 1'b1);  // 6 wraps to 0
        drive_b(SCN, 3'd0, 5'h1F, 9'h081, 3'd1, 1'b1, 1'b1);
        drive_b(SCN, 3'd0, 5'h1F, 9'h082, 3'd2, 1'b1, 1'b1);
        drive_b(SCN, 3'd0, 5'h1F, 9'h083, 3'd3, 1'b1, 1'b1);
        drive_b(SCN, 3'd0, 5'h1F, 9'h084, 3'd4, 1'b1, 1'b1);
        drive_b(SCN, 3'd0, 5'h1F, 9'h080, 3'd0, 1'b1, 1'b1);  // 4 wraps to 0
        drive_b(SCN, 3'd0, 5'h00, 9'h080, 3'd0, 1'b0, 1'b0);  // nothing enabled
        drive_b(SCN, 3'd0, 5'h04, 9'h082, 3'd2, 1'b1, 1'b1);
        mode_b = FRZ;

        // ---- instance a: manual select and one-cycle latency
        din_a[5*9 +: 9] = 9'h1A5;
        drive_a(MAN, 3'd5, 8'h00, 9'h1A5, 3'd5, 1'b1, 1'b0);
        din_a[5*9 +: 9] = 9'h0C3;
        drive_a(MAN, 3'd5, 8'h00, 9'h0C3, 3'd5, 1'b1, 1'b0);
        din_a[5*9 +: 9] = da(5);
        drive_a(MAN, 3'd2, 8'h00, da(2), 3'd2, 1'b1, 1'b0);
        drive_a(MAN, 3'd0, 8'h00, da(0), 3'd0, 1'b1, 1'b0);

        // Scan 0,2,5,7,0 with 4-cycle dwells; first edge clears the prescaler
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 4; j++)
                drive_a(SCN, 3'd0, 8'hA5, da(seq[i]), 3'(seq[i]), 1'b1, (i > 0) && (j == 0));

        // No channel enabled: hold, invalid, no step (two full dwells)
        for (int j = 0; j < 8; j++)
            drive_a(SCN, 3'd0, 8'h00, da(0), 3'd0, 1'b0, 1'b0);
        drive_a(SCN, 3'd0, 8'h08, da(3), 3'd3, 1'b1, 1'b1);
        // Disable the current channel mid-dwell
        drive_a(SCN, 3'd0, 8'h09, da(3), 3'd3, 1'b1, 1'b0);
        drive_a(SCN, 3'd0, 8'h01, da(3), 3'd3, 1'b0, 1'b0);
        drive_a(SCN, 3'd0, 8'h01, da(3), 3'd3, 1'b0, 1'b0);
        drive_a(SCN, 3'd0, 8'h01, da(0), 3'd0, 1'b1, 1'b1);
        // Only the current channel enabled: reselect it and still step
        for (int j = 0; j < 3; j++)
            drive_a(SCN, 3'd0, 8'h01, da(0), 3'd0, 1'b1, 1'b0);
        drive_a(SCN, 3'd0, 8'h01, da(0), 3'd0, 1'b1, 1'b1);

        // Freeze mid-dwell for 10 cycles while din changes underneath
        drive_a(SCN, 3'd0, 8'hA5, da(0), 3'd0, 1'b1, 1'b0);
        drive_a(SCN, 3'd0, 8'hA5, da(0), 3'd0, 1'b1, 1'b0);
        din_a[0 +: 9] = 9'h0AA;
        for (int j = 0; j < 10; j++)
            drive_a((j < 5) ? FRZ : RSV, 3'd4, 8'hFF, da(0), 3'd0, 1'b1, 1'b0);
        drive_a(SCN, 3'd0, 8'hA5, 9'h0AA, 3'd0, 1'b1, 1'b0);  // dwell restarts
        din_a[0 +: 9] = da(0);
        for (int j = 0; j < 3; j++)
            drive_a(SCN, 3'd0, 8'hA5, da(0), 3'd0, 1'b1, 1'b0);
        drive_a(SCN, 3'd0, 8'hA5, da(2), 3'd2, 1'b1, 1'b1);
        drive_a(SCN, 3'd0, 8'hA5, da(2), 3'd2, 1'b1, 1'b0);

        // Asynchronous reset between edges during scan
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_a", {dout_a, ch_a, valid_a, step_a}, 14'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 4; j++)
            drive_a(SCN, 3'd0, 8'hA5, da(0), 3'd0, 1'b1, 1'b0);
        drive_a(SCN, 3'd0, 8'hA5, da(2), 3'd2, 1'b1, 1'b1);

        // Let the monitor consume the last expectation
        @(posedge clk);
        #2;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain: got %0d pending, want 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_mux_scan_sel
